// File: rtl/double_edge_encode_if.sv
// Request/status bundle between a pulse source and double_edge_encode.
// The master drives pulse_in; the slave (encoder) drives the level and queue status.
interface double_edge_encode_if #(
  parameter int unsigned PEND_W = 2
) ();
  logic              pulse_in;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              overflow;

  modport master (output pulse_in, input out, input busy, input pend_cnt, input overflow);
  modport slave  (input pulse_in, output out, output busy, output pend_cnt, output overflow);
endinterface

// File: rtl/double_edge_encode.sv
// Converts one-cycle request pulses into level toggles spaced at least HOLD_CYCLES apart.
// Optional DOUBLE_EDGE_ENCODE_STICKY_OVF_EN makes overflow latch until reset.
module double_edge_encode #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned PEND_W      = 2
) (
  input logic                 clk,
  input logic                 reset,
  double_edge_encode_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0]        HOLD_RELOAD = 8'(HOLD_CYCLES - 32'd1);
  localparam logic [PEND_W-1:0] PEND_MAX    = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ZERO   = {PEND_W{1'b0}};
  localparam logic [PEND_W-1:0] PEND_ONE    = PEND_W'(1);

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        hold_r;
  logic [7:0]        hold_s;
  logic              out_r;
  logic              out_s;
  logic [PEND_W-1:0] pend_r;
  logic [PEND_W-1:0] pend_s;
  logic              ovf_r;
  logic              ovf_s;
  logic              avail_s;
  logic              toggle_s;
  logic              drop_s;

  assign avail_s = bus.pulse_in | (pend_r != PEND_ZERO);

  // State register and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      hold_r  <= 8'd0;
      out_r   <= 1'b0;
      pend_r  <= PEND_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      hold_r  <= hold_s;
      out_r   <= out_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
    end
  end

  // Next-state logic: decide whether this edge emits a toggle.
  always_comb begin
    state_s  = state_r;
    hold_s   = hold_r;
    toggle_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (avail_s) begin
          toggle_s = 1'b1;
          hold_s   = HOLD_RELOAD;
          state_s  = HOLD;
        end else begin
          state_s  = IDLE;
        end
      end
      HOLD: begin
        if (hold_r != 8'd0) begin
          hold_s = hold_r - 8'd1;
        end else if (avail_s) begin
          toggle_s = 1'b1;
          hold_s   = HOLD_RELOAD;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        hold_s  = 8'd0;
      end
    endcase
  end

  // Queue bookkeeping: a toggle drains the queue before consuming pulse_in directly.
  always_comb begin
    pend_s = pend_r;
    drop_s = 1'b0;
    out_s  = out_r ^ toggle_s;
    if (toggle_s) begin
      if ((pend_r != PEND_ZERO) && !bus.pulse_in) begin
        pend_s = pend_r - PEND_ONE;
      end else begin
        pend_s = pend_r;
      end
    end else if (bus.pulse_in) begin
      if (pend_r != PEND_MAX) begin
        pend_s = pend_r + PEND_ONE;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      pend_s = pend_r;
    end
  end

  // Overflow flag: one-cycle pulse per drop, or sticky until reset.
  always_comb begin
`ifdef DOUBLE_EDGE_ENCODE_STICKY_OVF_EN
    ovf_s = ovf_r | drop_s;
`else
    ovf_s = drop_s;
`endif
  end

  assign bus.out      = out_r;
  assign bus.pend_cnt = pend_r;
  assign bus.overflow = ovf_r;
  assign bus.busy     = (state_r != IDLE) | (pend_r != PEND_ZERO);

endmodule

// File: tb/tb_double_edge_encode.sv
// Bench for double_edge_encode: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances against
// a timing-rule model (toggle allowed when HOLD cycles have passed since the last one).
module tb_double_edge_encode;

  localparam int PMAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  double_edge_encode_if #(.PEND_W(2)) b4 ();
  double_edge_encode_if #(.PEND_W(2)) b1 ();

  double_edge_encode #(.HOLD_CYCLES(4), .PEND_W(2)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  double_edge_encode #(.HOLD_CYCLES(1), .PEND_W(2)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int edge_n = 0;
  int hold_v [2] = '{4, 1};
  int pend_m [2];
  int last_m [2];
  int out_m  [2];
  int ovf_m  [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend_m[i] = 0;
      last_m[i] = -100000;
      out_m[i]  = 0;
      ovf_m[i]  = 0;
    end
  endtask

  task automatic model_edge();
    logic p;
    int   drop;
    edge_n++;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        p    = (i == 0) ? b4.pulse_in : b1.pulse_in;
        drop = 0;
        if ((p || pend_m[i] > 0) && (edge_n - last_m[i] >= hold_v[i])) begin
          out_m[i]  = out_m[i] ^ 1;
          last_m[i] = edge_n;
          if (pend_m[i] > 0 && !p) pend_m[i]--;
        end else if (p) begin
          if (pend_m[i] < PMAX) pend_m[i]++;
          else drop = 1;
        end
`ifdef DOUBLE_EDGE_ENCODE_STICKY_OVF_EN
        ovf_m[i] = (ovf_m[i] != 0 || drop != 0) ? 1 : 0;
`else
        ovf_m[i] = drop;
`endif
      end
    end
  endtask

  function automatic int busy_m(input int i);
    return ((pend_m[i] > 0) || (edge_n - last_m[i] < hold_v[i])) ? 1 : 0;
  endfunction

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out4",  int'(b4.out),      out_m[0]);
      check("busy4", int'(b4.busy),     busy_m(0));
      check("pend4", int'(b4.pend_cnt), pend_m[0]);
      check("ovf4",  int'(b4.overflow), ovf_m[0]);
      check("out1",  int'(b1.out),      out_m[1]);
      check("busy1", int'(b1.busy),     busy_m(1));
      check("pend1", int'(b1.pend_cnt), pend_m[1]);
      check("ovf1",  int'(b1.overflow), ovf_m[1]);
    end
  end

  // One clock: drive pulses, let the edge happen, advance the model, return at negedge.
  task automatic cyc(input logic p4, input logic p1);
    b4.pulse_in = p4;
    b1.pulse_in = p1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_out4",  int'(b4.out), 0);
    check("rst_busy4", int'(b4.busy), 0);
    check("rst_pend4", int'(b4.pend_cnt), 0);
    check("rst_ovf4",  int'(b4.overflow), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int dens;
    b4.pulse_in = 1'b0;
    b1.pulse_in = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #1;
    check("por_out4",  int'(b4.out), 0);
    check("por_busy4", int'(b4.busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: two isolated pulses.
    idle(3);
    cyc(1'b1, 1'b0);
    check("t1_out_rise", int'(b4.out), 1);
    check("t1_busy",     int'(b4.busy), 1);
    idle(3);
    check("t1_busy_13",  int'(b4.busy), 1);
    idle(1);
    check("t1_busy_14",  int'(b4.busy), 0);
    check("t1_pend",     int'(b4.pend_cnt), 0);
    idle(5);
    cyc(1'b1, 1'b0);
    check("t1_out_fall", int'(b4.out), 0);
    idle(8);

    // Test 2: three-cycle burst queues two requests.
    do_reset();
    idle(2);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    check("t2_pend_11", int'(b4.pend_cnt), 1);
    cyc(1'b1, 1'b1);
    check("t2_pend_12", int'(b4.pend_cnt), 2);
    idle(2);
    check("t2_pend_14", int'(b4.pend_cnt), 1);
    idle(4);
    check("t2_pend_18", int'(b4.pend_cnt), 0);
    check("t2_out",     int'(b4.out), 1);
    idle(3);
    check("t2_busy_21", int'(b4.busy), 1);
    idle(1);
    check("t2_busy_22", int'(b4.busy), 0);

    // Test 3: six-cycle burst overflows the queue.
    do_reset();
    idle(2);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0);
    check("t3_pend_13", int'(b4.pend_cnt), 3);
    cyc(1'b1, 1'b0);
    check("t3_pend_14", int'(b4.pend_cnt), 3);
    check("t3_ovf_14",  int'(b4.overflow), 0);
    cyc(1'b1, 1'b0);
    check("t3_ovf_15",  int'(b4.overflow), 1);
    idle(1);
`ifdef DOUBLE_EDGE_ENCODE_STICKY_OVF_EN
    check("t3_ovf_16",  int'(b4.overflow), 1);
`else
    check("t3_ovf_16",  int'(b4.overflow), 0);
`endif
    idle(10);
    check("t3_pend_26", int'(b4.pend_cnt), 0);
    check("t3_out",     int'(b4.out), 1);
    idle(6);

    // Test 4: reset in the middle of a drained burst.
    do_reset();
    idle(2);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0);
    idle(3);
    check("t4_pend_15", int'(b4.pend_cnt), 1);
    check("t4_busy_15", int'(b4.busy), 1);
    do_reset();
    idle(10);
    check("t4_out_after",  int'(b4.out), 0);
    check("t4_busy_after", int'(b4.busy), 0);

    // Test 5: HOLD_CYCLES=1 toggles every clock.
    idle(2);
    cyc(1'b0, 1'b1);
    check("t5_out_5", int'(b1.out), 1);
    cyc(1'b0, 1'b1);
    check("t5_out_6", int'(b1.out), 0);
    cyc(1'b0, 1'b1);
    check("t5_out_7", int'(b1.out), 1);
    check("t5_pend",  int'(b1.pend_cnt), 0);
    check("t5_busy_7", int'(b1.busy), 1);
    idle(1);
    check("t5_busy_8", int'(b1.busy), 0);

    // Random traffic with varying density and occasional mid-cycle resets.
    dens = 30;
    for (int k = 0; k < 4000; k++) begin
      if (k % 200 == 0) dens = $urandom_range(5, 100);
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc(($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0,
          ($urandom_range(0, 99) < dens) ? 1'b1 : 1'b0);
    end
    idle(20);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
